// File: rtl/inst_enc.sv
// RV32I instruction encoder: range/format check plus field packing in the accept cycle,
// with results queued in a 2-entry output FIFO and accept/error counters.
module inst_enc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Req_valid_i,
    output logic        Req_ready_o,
    input  logic [2:0]  Fmt_i,
    input  logic [6:0]  Opcode_i,
    input  logic [4:0]  Rd_i,
    input  logic [4:0]  Rs1_i,
    input  logic [4:0]  Rs2_i,
    input  logic [2:0]  Funct3_i,
    input  logic [6:0]  Funct7_i,
    input  logic [31:0] Imm_i,
    output logic        Out_valid_o,
    input  logic        Out_ready_i,
    output logic [31:0] Inst_o,
    output logic        Err_o,
    output logic [15:0] Enc_cnt_o,
    output logic [7:0]  Err_cnt_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] w_raw;
    logic        w_bad;
    logic [31:0] w_inst;
    logic        w_fits12;
    logic        w_fits13;
    logic        w_fits21;
    logic        w_push;
    logic        w_pop;
    logic        w_wr_idx;

    logic [31:0] r_inst [2];
    logic        r_err  [2];
    logic        r_head;
    logic [1:0]  r_occ;
    logic [15:0] r_enc_cnt;
    logic [7:0]  r_err_cnt;

    // An immediate fits an N-bit signed field when all bits from N-1 upward are equal.
    assign w_fits12 = (&Imm_i[31:11]) | ~(|Imm_i[31:11]);
    assign w_fits13 = (&Imm_i[31:12]) | ~(|Imm_i[31:12]);
    assign w_fits21 = (&Imm_i[31:20]) | ~(|Imm_i[31:20]);

    always_comb begin
        w_raw = NOP;
        w_bad = 1'b0;
        case (Fmt_i)
            3'd0: w_raw = {Funct7_i, Rs2_i, Rs1_i, Funct3_i, Rd_i, Opcode_i};
            3'd1: begin
                w_raw = {Imm_i[11:0], Rs1_i, Funct3_i, Rd_i, Opcode_i};
                w_bad = ~w_fits12;
            end
            3'd2: begin
                w_raw = {Imm_i[11:5], Rs2_i, Rs1_i, Funct3_i, Imm_i[4:0], Opcode_i};
                w_bad = ~w_fits12;
            end
            3'd3: begin
                w_raw = {Imm_i[12], Imm_i[10:5], Rs2_i, Rs1_i, Funct3_i,
                         Imm_i[4:1], Imm_i[11], Opcode_i};
                w_bad = ~w_fits13 | Imm_i[0];
            end
            3'd4: begin
                w_raw = {Imm_i[31:12], Rd_i, Opcode_i};
                w_bad = |Imm_i[11:0];
            end
            3'd5: begin
                w_raw = {Imm_i[20], Imm_i[10:1], Imm_i[11], Imm_i[19:12], Rd_i, Opcode_i};
                w_bad = ~w_fits21 | Imm_i[0];
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign w_inst = w_bad ? NOP : w_raw;

    assign Req_ready_o = ~r_occ[1];
    assign Out_valid_o = (r_occ != 2'd0);
    assign w_push      = Req_valid_i & Req_ready_o;
    assign w_pop       = Out_valid_o & Out_ready_i;
    // Tail slot is head when empty, the other slot when one entry is held.
    assign w_wr_idx    = r_head ^ r_occ[0];

    assign Inst_o    = Out_valid_o ? r_inst[r_head] : 32'd0;
    assign Err_o     = Out_valid_o ? r_err[r_head] : 1'b0;
    assign Enc_cnt_o = r_enc_cnt;
    assign Err_cnt_o = r_err_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_inst[0] <= 32'd0;
            r_inst[1] <= 32'd0;
            r_err[0]  <= 1'b0;
            r_err[1]  <= 1'b0;
            r_head    <= 1'b0;
            r_occ     <= 2'd0;
            r_enc_cnt <= 16'd0;
            r_err_cnt <= 8'd0;
        end else begin
            if (w_push) begin
                r_inst[w_wr_idx] <= w_inst;
                r_err[w_wr_idx]  <= w_bad;
                r_enc_cnt        <= r_enc_cnt + 16'd1;
                if (w_bad && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_inst_enc.sv
// Bench for inst_enc: directed vector table, multi-cycle corner sequences,
// and a randomized run scored against a queue-based reference model.
module tb_inst_enc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        err;
  logic [15:0] enc_cnt;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  inst_enc dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .Req_valid_i (req_valid),
    .Req_ready_o (req_ready),
    .Fmt_i       (fmt),
    .Opcode_i    (opcode),
    .Rd_i        (rd),
    .Rs1_i       (rs1),
    .Rs2_i       (rs2),
    .Funct3_i    (funct3),
    .Funct7_i    (funct7),
    .Imm_i       (imm),
    .Out_valid_o (out_valid),
    .Out_ready_i (out_ready),
    .Inst_o      (inst),
    .Err_o       (err),
    .Enc_cnt_o   (enc_cnt),
    .Err_cnt_o   (err_cnt)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [32:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_enc;
  int          exp_errc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input vec_t v);
    req_valid = 1'b1;
    fmt = v.fmt; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  // Reference: bit ranges pulled out arithmetically, legality from signed integer ranges.
  function automatic logic [31:0] fld(input logic [31:0] x, input int hi, input int lo);
    return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic logic [32:0] ref_enc(input vec_t v);
    longint      s;
    logic [31:0] x;
    bit          bad;
    s   = longint'($signed(v.imm));
    x   = 32'(v.op) | (32'(v.f3) << 12) | (32'(v.rs1) << 15);
    bad = 1'b0;
    case (v.fmt)
      3'd0: x = x | (32'(v.rd) << 7) | (32'(v.rs2) << 20) | (32'(v.f7) << 25);
      3'd1: begin
        x = x | (32'(v.rd) << 7) | (fld(v.imm, 11, 0) << 20);
        bad = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        x = x | (fld(v.imm, 4, 0) << 7) | (32'(v.rs2) << 20) | (fld(v.imm, 11, 5) << 25);
        bad = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        x = x | (fld(v.imm, 11, 11) << 7) | (fld(v.imm, 4, 1) << 8) | (32'(v.rs2) << 20)
              | (fld(v.imm, 10, 5) << 25) | (fld(v.imm, 12, 12) << 31);
        bad = (s < -4096) || (s > 4094) || (s % 2 != 0);
      end
      3'd4: begin
        x = 32'(v.op) | (32'(v.rd) << 7) | (fld(v.imm, 31, 12) << 12);
        bad = (s % 4096 != 0);
      end
      3'd5: begin
        x = 32'(v.op) | (32'(v.rd) << 7) | (fld(v.imm, 19, 12) << 12) | (fld(v.imm, 11, 11) << 20)
              | (fld(v.imm, 10, 1) << 21) | (fld(v.imm, 20, 20) << 31);
        bad = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      end
      default: bad = 1'b1;
    endcase
    if (bad) x = 32'h0000_0013;
    return {bad, x};
  endfunction

  function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] im,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.fmt = f; v.op = op; v.rd = d; v.rs1 = a; v.rs2 = b; v.f3 = f3; v.f7 = f7;
    v.imm = im; v.exp_inst = ei; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    vec_t v;
    vec_t a_req, b_req, c_req;
    logic [32:0] e;
    int    n_err_vec;
    bit    acc, pop;
    int    bnd[13] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                       1048574, 1048576, -1048576, -1048578};

    rst_n = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;

    vecs.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0));
    vecs.push_back(mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,         32'h0020_A423, 1'b0));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0));
    vecs.push_back(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0));
    vecs.push_back(mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,         32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,         32'h0020_81B3, 1'b0));
    vecs.push_back(mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,         32'h4020_81B3, 1'b0));
    vecs.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,      32'h7FF0_0093, 1'b0));
    vecs.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0));
    vecs.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,      32'h7E00_0FE3, 1'b0));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,      32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2,         32'h0000_0163, 1'b0));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,         32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000F_FFFE, 32'h7FFF_F06F, 1'b0));
    vecs.push_back(mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF0_0000, 32'h8000_006F, 1'b0));
    vecs.push_back(mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd6, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0,         32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd7, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0,         32'h0000_0013, 1'b1));

    // Reset state
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Directed table, streamed with the consumer always ready
    out_ready = 1'b1;
    n_err_vec = 0;
    foreach (vecs[i]) begin
      drive_req(vecs[i]);
      cycle();
      if (vecs[i].exp_err) n_err_vec++;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_inst", i), inst, vecs[i].exp_inst);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
    end
    req_valid = 1'b0;
    cycle();
    chk("vec_drain_valid", 32'(out_valid), 32'd0);
    chk("vec_enc_cnt", 32'(enc_cnt), 32'(vecs.size()));
    chk("vec_err_cnt", 32'(err_cnt), 32'(n_err_vec));

    // Lone error request from a clean reset
    do_reset();
    out_ready = 1'b1;
    drive_req(vecs[4]);
    cycle();
    req_valid = 1'b0;
    chk("jerr_inst", inst, 32'h0000_0013);
    chk("jerr_err", 32'(err), 32'd1);
    chk("jerr_err_cnt", 32'(err_cnt), 32'd1);

    // Backpressure: two accepted, third held off, then in-order drain
    a_req = vecs[0]; b_req = vecs[1]; c_req = vecs[3];
    do_reset();
    out_ready = 1'b0;
    drive_req(a_req);
    cycle();
    chk("bp_ready_after_a", 32'(req_ready), 32'd1);
    drive_req(b_req);
    cycle();
    chk("bp_ready_full", 32'(req_ready), 32'd0);
    chk("bp_head_a", inst, a_req.exp_inst);
    drive_req(c_req);
    cycle();
    chk("bp_ready_still_full", 32'(req_ready), 32'd0);
    chk("bp_enc_cnt_2", 32'(enc_cnt), 32'd2);
    cycle();
    chk("bp_head_stable", inst, a_req.exp_inst);
    chk("bp_valid_stable", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cycle();
    chk("bp_drain_b", inst, b_req.exp_inst);
    cycle();
    req_valid = 1'b0;
    chk("bp_drain_c", inst, c_req.exp_inst);
    cycle();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_enc_cnt_3", 32'(enc_cnt), 32'd3);

    // Reset while the FIFO is full and a request is presented
    do_reset();
    out_ready = 1'b0;
    drive_req(vecs[4]);
    cycle();
    drive_req(vecs[1]);
    cycle();
    chk("mid_full", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive_req(vecs[0]);
    cycle();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_enc", 32'(enc_cnt), 32'd0);
    chk("mid_rst_errc", 32'(err_cnt), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    req_valid = 1'b0;
    cycle();
    chk("mid_post_valid", 32'(out_valid), 32'd0);
    chk("mid_post_enc", 32'(enc_cnt), 32'd0);

    // Error counter saturation
    do_reset();
    out_ready = 1'b1;
    drive_req(vecs[19]);
    for (int i = 0; i < 300; i++) cycle();
    req_valid = 1'b0;
    chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
    chk("sat_enc_cnt", 32'(enc_cnt), 32'd300);

    // Randomized traffic against the queue model
    do_reset();
    exp_q.delete();
    exp_enc = 0;
    exp_errc = 0;
    for (int c = 0; c < 3000; c++) begin
      v.fmt = 3'($urandom_range(0, 7));
      v.op  = 7'($urandom); v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
      v.f3  = 3'($urandom); v.f7 = 7'($urandom);
      case ($urandom_range(0, 4))
        0: v.imm = 32'(int'($urandom_range(0, 10000)) - 5000);
        1: v.imm = 32'(bnd[$urandom_range(0, 12)] + int'($urandom_range(0, 2)) - 1);
        2: v.imm = $urandom();
        3: v.imm = $urandom() & 32'hFFFF_F000;
        default: v.imm = 32'(int'($urandom_range(0, 4194304)) - 2097152);
      endcase
      v.exp_inst = '0; v.exp_err = 1'b0;
      drive_req(v);
      req_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      chk("rnd_ready", 32'(req_ready), 32'(exp_q.size() < 2));
      chk("rnd_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("rnd_inst", inst, exp_q[0][31:0]);
        chk("rnd_err", 32'(err), 32'(exp_q[0][32]));
      end
      chk("rnd_enc_cnt", 32'(enc_cnt), 32'(exp_enc & 16'hFFFF));
      chk("rnd_err_cnt", 32'(err_cnt), 32'(exp_errc));
      acc = req_valid && (exp_q.size() < 2);
      pop = out_ready && (exp_q.size() > 0);
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        e = ref_enc(v);
        exp_q.push_back(e);
        exp_enc++;
        if (e[32] && exp_errc < 255) exp_errc++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_enc.md
INST_ENC -- requirements
Module: Inst_Enc

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port Req_valid_i, input, 1 bit: an encode request is present.
REQ-004 SHALL have port Req_ready_o, output, 1 bit: the block can accept a request this cycle.
REQ-005 SHALL have port Fmt_i, input, 3 bits: instruction format, 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal.
REQ-006 SHALL have port Opcode_i, input, 7 bits: opcode, placed in bits [6:0].
REQ-007 SHALL have ports Rd_i, Rs1_i and Rs2_i, input, 5 bits each: register fields.
REQ-008 SHALL have ports Funct3_i (input, 3 bits) and Funct7_i (input, 7 bits): function fields.
REQ-009 SHALL have port Imm_i, input, 32 bits: sign-extended immediate value to encode.
REQ-010 SHALL have port Out_valid_o, output, 1 bit: Inst_o and Err_o hold a valid result.
REQ-011 SHALL have port Out_ready_i, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port Inst_o, output, 32 bits: encoded instruction.
REQ-013 SHALL have port Err_o, output, 1 bit: the request failed its range/format check.
REQ-014 SHALL have port Enc_cnt_o, output, 16 bits: count of accepted requests.
REQ-015 SHALL have port Err_cnt_o, output, 8 bits: count of failed requests.

Function
REQ-016 SHALL encode each format in standard RV32I field layout: R = f7|rs2|rs1|f3|rd|op; I = imm[11:0]|rs1|f3|rd|op; S = imm[11:5]|rs2|rs1|f3|imm[4:0]|op; B = imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op; U = imm[31:12]|rd|op; J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
REQ-017 SHALL flag an error when any of these holds: I/S imm outside [-2048, 2047]; B imm outside [-4096, 4094] or odd; J imm outside [-2^20, 2^20-2] or odd; U imm[11:0] nonzero; Fmt_i equal to 6 or 7.
REQ-018 SHALL produce an error entry with Inst_o=32'h00000013 (NOP) and Err_o=1; a clean entry SHALL carry Err_o=0.
REQ-019 SHALL accept a request on any cycle in which both Req_valid_i and Req_ready_o are 1; encoding and checking SHALL complete in that same cycle, and the result SHALL be written into a 2-entry output FIFO.
REQ-020 SHALL drive Req_ready_o = 1 whenever the FIFO holds fewer than 2 entries, combinationally from the occupancy only and independent of Out_ready_i.
REQ-021 SHALL drive Out_valid_o = 1 whenever the FIFO holds at least 1 entry, with Inst_o and Err_o taken from the head entry.
REQ-022 SHALL pop the head entry on a cycle in which both Out_valid_o and Out_ready_i are 1.
REQ-023 SHALL have a latency of 1 cycle: a request accepted in cycle N with the FIFO empty (or emptied by a pop in cycle N) SHALL appear on the outputs in cycle N+1.
REQ-024 SHALL handle simultaneous push and pop with occupancy 1 by leaving occupancy at 1 and making the new entry the head.
REQ-025 SHALL, with occupancy 2, hold Req_ready_o = 0; a pop in that cycle SHALL NOT allow a push in the same cycle.
REQ-026 SHALL increment Enc_cnt_o by 1 on every accepted request, wrapping from 16'hFFFF to 0.
REQ-027 SHALL increment Err_cnt_o by 1 on every accepted request that fails its check, saturating at 8'hFF.
REQ-028 SHALL hold the Inst_o/Err_o values of the head entry stable while Out_valid_o=1 and Out_ready_i=0.

Reset
REQ-029 SHALL, on a clock edge with rst_i=0, empty the FIFO and clear the counters: Out_valid_o=0, Inst_o=0, Err_o=0, Enc_cnt_o=0, Err_cnt_o=0.
REQ-030 SHALL, on reset mid-operation, discard any buffered entries and ignore any request presented in the reset cycle.
REQ-031 SHALL drive Req_ready_o = 1 in the first cycle after reset is released.

Verification
REQ-032 SHALL be verified with scenario I-format: Fmt=1, op=0x13, rd=1, rs1=0, f3=0, Imm=32'hFFFFFFFF -> next cycle Inst_o=32'hFFF00093, Err_o=0.
REQ-033 SHALL be verified with scenario S/B-format: S, op=0x23, f3=2, rs1=1, rs2=2, Imm=8 -> 32'h0020A423; B, op=0x63, all registers 0, Imm=-4 -> 32'hFE000EE3.
REQ-034 SHALL be verified with scenario U-format and error check: U, op=0x37, rd=5, Imm=32'h12345000 -> 32'h123452B7; J with Imm=3 -> Inst_o=32'h00000013, Err_o=1, Err_cnt_o=1.
REQ-035 SHALL be verified with scenario backpressure: Out_ready_i=0 and 3 back-to-back requests -> 2 accepted, Req_ready_o=0 on the third, outputs stable; then Out_ready_i=1 -> entries drain in order, Enc_cnt_o=3.
REQ-036 SHALL be verified with scenario reset mid-stream: FIFO holding 2 entries, rst_i=0 for 1 cycle -> Out_valid_o=0, both counters 0, Req_ready_o=1 after release.
